// File: rtl/rs232_rx.sv
// rs232_rx -- 8N1 UART receiver, companion to the RS-232 transmitter.
//
// Oversamples i_rx with the system clock and samples each bit at mid-period.
// The stop bit is checked, and each good byte is handed over through a
// one-entry holding register with a valid/ack handshake.
//
// Optional build macro: RS232_RX_MAJORITY_EN
//   defined   : each sample is the 2-of-3 vote of rx_s at point-1, point and
//               point+1. Single-clock glitches are rejected, at the cost of
//               one extra clock of latency.
//   undefined : single sample at the point itself.
//
// Ports:
//   i_clk          system clock (50 MHz)
//   i_rst          asynchronous reset, active low
//   i_baud_setting bit period: 00 = DIV_9600, 01 = /2, 1x = /4
//   i_rx           asynchronous serial line, idles high
//   i_rx_ack       consumer acknowledge; clears o_rx_valid and o_overrun
//   o_rx_data      last accepted byte; stable while o_rx_valid = 1
//   o_rx_valid     byte available; held until i_rx_ack
//   o_frame_err    one-cycle pulse when the stop bit samples 0
//   o_overrun      sticky; a byte completed while o_rx_valid was 1
//   o_busy         high from start detection until the return to IDLE
//
// State table:
//   S_IDLE      | line idle, waiting for a falling edge
//   S_START     | checking the start bit at mid-bit
//   S_DATA      | sampling 8 data bits, LSB first
//   S_STOP      | checking the stop bit
//   S_WAIT_HIGH | after a framing error, waiting for the line to go high

module rs232_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_9600    = 5208
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_baud_setting,
  input  logic       i_rx,
  input  logic       i_rx_ack,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

  localparam logic [15:0] DIV_FULL    = 16'(DIV_9600);
  localparam logic [15:0] DIV_HALF    = 16'(DIV_9600 / 2);
  localparam logic [15:0] DIV_QUARTER = 16'(DIV_9600 / 4);

  // The majority vote ends one clock after the nominal start sample. The
  // later data and stop samples stay one clock late because the counter
  // restarts from there.
`ifdef RS232_RX_MAJORITY_EN
  localparam logic [15:0] START_OFS = 16'd0;
`else
  localparam logic [15:0] START_OFS = 16'd1;
`endif

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  logic [15:0]            r_div, r_baud_cnt;
  logic [3:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   w_rx_s, w_fall, w_bit, w_tick;
  logic [15:0]            w_div_sel, w_half, w_point;
  logic                   w_latch, w_shift_en, w_deliver, w_ferr, w_cnt_clr, w_counting;

  // The synchronizer is preset to idle-high, so reset release cannot look
  // like a start bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rx_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_fall = r_rx_d & ~w_rx_s;

`ifdef RS232_RX_MAJORITY_EN
  logic [1:0] r_hist;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], w_rx_s};
  end
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rx_s) | (r_hist[0] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  always_comb begin
    unique case (i_baud_setting)
      2'b00:   w_div_sel = DIV_FULL;
      2'b01:   w_div_sel = DIV_HALF;
      default: w_div_sel = DIV_QUARTER;
    endcase
  end

  assign w_half  = r_div >> 1;
  assign w_point = (r_state == S_START) ? (w_half - START_OFS) : (r_div - 16'd1);
  assign w_tick  = (r_baud_cnt == w_point);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_shift_en  = 1'b0;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    w_counting  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nxt = S_START;
          w_latch     = 1'b1;
        end
      end
      S_START: begin
        w_counting = 1'b1;
        if (w_tick) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        w_counting = 1'b1;
        if (w_tick) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 4'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_counting = 1'b1;
        if (w_tick) begin
          w_deliver   = w_bit;
          w_ferr      = ~w_bit;
          w_state_nxt = w_bit ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The counter restarts on every sample and every state change, so each
    // bit window is measured from the previous sample point.
    w_cnt_clr = (w_state_nxt != r_state) || (w_counting && w_tick);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_div       <= '0;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      o_rx_data   <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (w_latch) r_div <= w_div_sel;

      if (w_cnt_clr)       r_baud_cnt <= '0;
      else if (w_counting) r_baud_cnt <= r_baud_cnt + 16'd1;

      if (w_shift_en) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= (r_bit_cnt == 4'd7) ? 4'd0 : r_bit_cnt + 4'd1;
      end

      o_frame_err <= w_ferr;

      // If an ack arrives in the same cycle as a new byte, the new byte is
      // accepted and no overrun is recorded.
      if (w_deliver) begin
        if (!o_rx_valid || i_rx_ack) begin
          o_rx_data  <= r_shift;
          o_rx_valid <= 1'b1;
          o_overrun  <= 1'b0;
        end else begin
          o_overrun  <= 1'b1;
        end
      end else if (i_rx_ack) begin
        o_rx_valid <= 1'b0;
        o_overrun  <= 1'b0;
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);

endmodule
